// File: rtl/boot_loader.sv
// Copies a block of words from storage into instruction memory (2 cycles/word) with the CPU stalled, then optionally hands fetch over from BIOS.
// Optional running checksum of copied words when BOOT_LOADER_CHECKSUM_EN is defined.
module boot_loader #(
  parameter int ADDR_WIDTH = 26,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  handoff,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  src_rd,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [31:0]           src_data,
  output logic                  dst_we,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic [31:0]           dst_data,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_stall,
  output logic                  sel_bios,
  output logic [31:0]           checksum
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] src_addr_q, dst_ptr_q, dst_addr_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic [31:0]           dst_data_q;
  logic                  handoff_q, src_rd_q, dst_we_q, busy_q, done_q, sel_bios_q;

  logic [ADDR_WIDTH-1:0] src_ptr_d, dst_ptr_d;
  logic [LEN_WIDTH-1:0]  remain_d;

  // src_addr_q doubles as the source pointer; dst_addr_q is kept apart so it holds between writes.
  assign src_ptr_d = src_addr_q + ADDR_WIDTH'(1);
  assign dst_ptr_d = dst_ptr_q + ADDR_WIDTH'(1);
  assign remain_d  = remain_q - LEN_WIDTH'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_addr_q <= '0;
      dst_ptr_q  <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      remain_q   <= '0;
      handoff_q  <= 1'b0;
      src_rd_q   <= 1'b0;
      dst_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_bios_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            handoff_q  <= handoff;
            src_addr_q <= src_base;
            dst_ptr_q  <= dst_base;
            remain_q   <= length;
            busy_q     <= 1'b1;
            if (length == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
              if (handoff) sel_bios_q <= 1'b0;
            end else begin
              state_q  <= READ;
              src_rd_q <= 1'b1;
            end
          end
        end
        READ: begin
          src_rd_q   <= 1'b0;
          dst_we_q   <= 1'b1;
          dst_addr_q <= dst_ptr_q;
          state_q    <= WRITE;
        end
        WRITE: begin
          dst_we_q   <= 1'b0;
          dst_data_q <= src_data;
          src_addr_q <= src_ptr_d;
          dst_ptr_q  <= dst_ptr_d;
          remain_q   <= remain_d;
          if (remain_d != '0) begin
            state_q  <= READ;
            src_rd_q <= 1'b1;
          end else begin
            state_q <= FINISH;
            done_q  <= 1'b1;
            if (handoff_q) sel_bios_q <= 1'b0;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_rd    = src_rd_q;
  assign src_addr  = src_addr_q;
  assign dst_we    = dst_we_q;
  assign dst_addr  = dst_addr_q;
  // Read data only arrives in the WRITE cycle, so it is forwarded straight through while writing.
  assign dst_data  = dst_we_q ? src_data : dst_data_q;
  assign busy      = busy_q;
  assign cpu_stall = busy_q;
  assign done      = done_q;
  assign sel_bios  = sel_bios_q;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (state_q == IDLE && start) begin
      checksum_q <= '0;
    end else if (dst_we_q) begin
      checksum_q <= checksum_q + src_data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 26: width of the source, destination and PC-side word addresses.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of the transfer word count.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  copy request, sampled only in IDLE.
REQ-006 SHALL have port handoff  input  1  sampled with start; when high, fetch is switched away from BIOS on completion.
REQ-007 SHALL have port src_base  input  ADDR_WIDTH  first source word address (disk/storage).
REQ-008 SHALL have port dst_base  input  ADDR_WIDTH  first destination word address (instruction memory).
REQ-009 SHALL have port length  input  LEN_WIDTH  number of words to copy.
REQ-010 SHALL have port src_rd  output  1  source read strobe.
REQ-011 SHALL have port src_addr  output  ADDR_WIDTH  source read address.
REQ-012 SHALL have port src_data  input  32  source read data, valid exactly one cycle after src_rd.
REQ-013 SHALL have port dst_we  output  1  instruction-memory write enable.
REQ-014 SHALL have port dst_addr  output  ADDR_WIDTH  instruction-memory write address.
REQ-015 SHALL have port dst_data  output  32  instruction-memory write data.
REQ-016 SHALL have port busy  output  1  high while a copy is in progress.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port cpu_stall  output  1  freezes the processor PC while high.
REQ-019 SHALL have port sel_bios  output  1  1 = instruction fetch from BIOS ROM, 0 = from instruction memory.
REQ-020 SHALL have port checksum  output  32  running sum of copied words (see Configuration).

Function
REQ-021 SHALL implement the FSM states IDLE, READ, WRITE and FINISH.
REQ-022 SHALL, in IDLE with start=1: latch src_base, dst_base, length and handoff; go to FINISH if length=0, else to READ.
REQ-023 SHALL, in READ: assert src_rd with src_addr = current source pointer, then go to WRITE.
REQ-024 SHALL, in WRITE: assert dst_we with dst_addr = current destination pointer and dst_data = src_data; increment both pointers and decrement the remaining count.
REQ-025 SHALL, after WRITE: go to READ if the remaining count is nonzero, else to FINISH.
REQ-026 SHALL, in FINISH: pulse done for one cycle, clear sel_bios if the latched handoff=1, then return to IDLE.
REQ-027 SHALL take 2 cycles per word: busy is high for exactly 2*length+1 cycles (READ, WRITE and FINISH states); cpu_stall = busy.
REQ-028 SHALL increment pointers modulo 2^ADDR_WIDTH; a wrap continues silently at address 0.
REQ-029 SHALL ignore start while not in IDLE; start in the same cycle as FINISH is also ignored.
REQ-030 SHALL never assert src_rd and dst_we in the same cycle.
REQ-031 SHALL drive src_rd and dst_we to 0 outside READ and WRITE respectively.
REQ-032 SHALL hold dst_addr and dst_data at their last values when dst_we=0.
REQ-033 SHALL keep sel_bios at 0 once cleared until reset; a later copy with handoff=0 does not restore it.

Reset
REQ-034 SHALL, on reset: enter IDLE with busy=0, done=0, cpu_stall=0, src_rd=0, dst_we=0, src_addr=0, dst_addr=0, dst_data=0, sel_bios=1, checksum=0.
REQ-035 SHALL abort a copy on reset mid-operation: no further writes after reset asserts, sel_bios returns to 1 and done is not pulsed.

Configuration
REQ-036 SHALL, with BOOT_LOADER_CHECKSUM_EN defined: clear checksum on an accepted start, add each dst_data to it as a 32-bit wrapping sum on every WRITE, and hold it after FINISH.
REQ-037 SHALL, without BOOT_LOADER_CHECKSUM_EN: keep the checksum port present but tied to 0, with no adder logic.

Verification
REQ-038 SHALL cover a basic copy: src_base=0x100, dst_base=0x0, length=3, source words A,B,C -> writes at 0,1,2 with data A,B,C; busy for 7 cycles; one done pulse.
REQ-039 SHALL cover a zero-length copy: length=0, handoff=1 -> no src_rd and no dst_we; busy for 1 cycle; done pulses; sel_bios goes to 0.
REQ-040 SHALL cover address wrap: dst_base=0x3FFFFFF, length=2 -> writes at 0x3FFFFFF then 0x0000000.
REQ-041 SHALL cover start while busy: start pulsed during word 2 of a length=4 copy -> exactly 4 writes and a single done pulse.
REQ-042 SHALL cover reset mid-operation: reset asserted in WRITE of word 1 of a length=5 copy -> dst_we=0 immediately, sel_bios=1, busy=0, no done pulse.
REQ-043 SHALL cover the checksum (macro defined): words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001 after done.
